ultrasonic_scheduler: RTL and testbench

ULTRASONIC_SCHEDULER -- requirements
Module: ultrasonic_scheduler

---
 rtl/ultrasonic_scheduler_pkg.sv | 40 ++++
 rtl/ultrasonic_level_classifier.sv | 43 ++++
 rtl/ultrasonic_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_ultrasonic_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ultrasonic_scheduler_pkg                                        |
// | Purpose  : Shared types and constants for the two-sensor ultrasonic        |
// |            ranging scheduler: FSM state encoding, default timing and       |
// |            classification thresholds, datapath widths, trigger helper.     |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package ultrasonic_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  // Default timing at 50 MHz: 10 us trigger, 38 ms echo window, 60 ms gap.
  localparam int c_TRIG_CYCLES  = 500;
  localparam int c_ECHO_TIMEOUT = 1900000;
  localparam int c_GAP_CYCLES   = 3000000;

  // Default distance-class thresholds, in echo high-time cycles.
  localparam int c_TH1 = 3000;
  localparam int c_TH2 = 30000;
  localparam int c_TH3 = 60000;

  // Result width holds ECHO_TIMEOUT; the shared counter must also hold GAP_CYCLES.
  localparam int c_RES_W = 21;
  localparam int c_CNT_W = 22;

  // Trigger pattern for the selected sensor.
  function automatic logic [1:0] sel_onehot(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ultrasonic_level_classifier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ultrasonic_level_classifier                                     |
// | Purpose  : Combinational mapping of a measured echo time to a 2-bit        |
// |            distance class. A timed-out measurement is always class 3.      |
// | Ports    : cycles  - measured echo high time in clk cycles                 |
// |            timeout - measurement ended by timeout                          |
// |            level   - class: 0 (<TH1), 1 (<TH2), 2 (<TH3), 3 (otherwise)    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ultrasonic_level_classifier
  import ultrasonic_scheduler_pkg::*;
#(
  parameter int TH1 = c_TH1,
  parameter int TH2 = c_TH2,
  parameter int TH3 = c_TH3
) (
  input  logic [c_RES_W-1:0] cycles,
  input  logic               timeout,
  output logic [1:0]         level
);

  localparam logic [c_RES_W-1:0] c_TH1_V = c_RES_W'(TH1);
  localparam logic [c_RES_W-1:0] c_TH2_V = c_RES_W'(TH2);
  localparam logic [c_RES_W-1:0] c_TH3_V = c_RES_W'(TH3);

  always_comb begin
    level = 2'd3;
    if (timeout) begin
      level = 2'd3;
    end else if (cycles < c_TH1_V) begin
      level = 2'd0;
    end else if (cycles < c_TH2_V) begin
      level = 2'd1;
    end else if (cycles < c_TH3_V) begin
      level = 2'd2;
    end else begin
      level = 2'd3;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ultrasonic_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ultrasonic_scheduler                                            |
// | Purpose  : Round-robin scheduler for two ultrasonic range sensors.         |
// |            Pulses the trigger of one sensor, times its echo pulse,         |
// |            publishes the result and a distance class, waits a gap and      |
// |            moves to the other sensor.                                      |
// | Ports    : clk            - system clock                                   |
// |            rst_n          - asynchronous active-low reset                  |
// |            enable         - run the measurement schedule                   |
// |            echo[1:0]      - raw (asynchronous) echo lines                  |
// |            trigger[1:0]   - sensor trigger lines, one-hot or zero          |
// |            result_valid   - one-cycle pulse on each new result             |
// |            result_id      - sensor index of the current result             |
// |            result_cycles  - echo high time, saturated at ECHO_TIMEOUT      |
// |            result_timeout - measurement ended by timeout                   |
// |            level0/level1  - per-sensor distance class, held               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ultrasonic_scheduler
  import ultrasonic_scheduler_pkg::*;
#(
  parameter int TRIG_CYCLES  = c_TRIG_CYCLES,
  parameter int ECHO_TIMEOUT = c_ECHO_TIMEOUT,
  parameter int GAP_CYCLES   = c_GAP_CYCLES,
  parameter int TH1          = c_TH1,
  parameter int TH2          = c_TH2,
  parameter int TH3          = c_TH3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [1:0]         echo,
  output logic [1:0]         trigger,
  output logic               result_valid,
  output logic               result_id,
  output logic [c_RES_W-1:0] result_cycles,
  output logic               result_timeout,
  output logic [1:0]         level0,
  output logic [1:0]         level1
);

  localparam logic [c_CNT_W-1:0] c_TRIG_LAST = c_CNT_W'(TRIG_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(ECHO_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_MEAS_MAX  = c_CNT_W'(ECHO_TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(GAP_CYCLES - 1);

  state_t             r_state;
  logic               r_sel;
  logic [c_CNT_W-1:0] r_cnt;

  logic [1:0] r_echo_meta;
  logic [1:0] r_echo_sync;
  logic [1:0] r_echo_prev;

  logic               w_echo_cur;
  logic               w_echo_last;
  logic               w_rise;
  logic               w_fall;
  logic               w_pub;
  logic [c_RES_W-1:0] w_pub_cycles;
  logic               w_pub_timeout;
  logic [1:0]         w_pub_level;

  // Two-flop synchronizer per echo line, plus one more stage so edges are
  // judged on synchronized samples only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_echo_meta <= 2'b00;
      r_echo_sync <= 2'b00;
      r_echo_prev <= 2'b00;
    end else begin
      r_echo_meta <= echo;
      r_echo_sync <= r_echo_meta;
      r_echo_prev <= r_echo_sync;
    end
  end

  // Only the selected sensor's line is examined. Because the edge needs a
  // low sample followed by a high one, a line already high on entry to
  // WAIT_RISE does not start a measurement.
  always_comb begin
    w_echo_cur    = r_echo_sync[r_sel];
    w_echo_last   = r_echo_prev[r_sel];
    w_rise        = w_echo_cur & ~w_echo_last;
    w_fall        = ~w_echo_cur & w_echo_last;
    w_pub         = 1'b0;
    w_pub_cycles  = '0;
    w_pub_timeout = 1'b0;
    case (r_state)
      ST_WAIT_RISE: begin
        // A rise on the last waiting cycle still wins over the timeout.
        if (!w_rise && (r_cnt == c_WAIT_LAST)) begin
          w_pub         = 1'b1;
          w_pub_timeout = 1'b1;
        end
      end
      ST_MEASURE: begin
        // r_cnt equals the number of synchronized high cycles seen so far.
        if (w_fall) begin
          w_pub        = 1'b1;
          w_pub_cycles = r_cnt[c_RES_W-1:0];
        end else if (r_cnt == c_MEAS_MAX) begin
          w_pub         = 1'b1;
          w_pub_cycles  = c_RES_W'(ECHO_TIMEOUT);
          w_pub_timeout = 1'b1;
        end
      end
      default: ;
    endcase
  end

  ultrasonic_level_classifier #(
    .TH1 (TH1),
    .TH2 (TH2),
    .TH3 (TH3)
  ) u_classifier (
    .cycles  (w_pub_cycles),
    .timeout (w_pub_timeout),
    .level   (w_pub_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_sel          <= 1'b0;
      r_cnt          <= '0;
      trigger        <= 2'b00;
      result_valid   <= 1'b0;
      result_id      <= 1'b0;
      result_cycles  <= '0;
      result_timeout <= 1'b0;
      level0         <= 2'd0;
      level1         <= 2'd0;
    end else begin
      result_valid <= w_pub;
      if (w_pub) begin
        result_id      <= r_sel;
        result_cycles  <= w_pub_cycles;
        result_timeout <= w_pub_timeout;
        if (r_sel) begin
          level1 <= w_pub_level;
        end else begin
          level0 <= w_pub_level;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state <= ST_TRIG;
            r_cnt   <= '0;
            trigger <= sel_onehot(r_sel);
          end
        end
        ST_TRIG: begin
          if (r_cnt == c_TRIG_LAST) begin
            r_state <= ST_WAIT_RISE;
            r_cnt   <= '0;
            trigger <= 2'b00;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT_RISE: begin
          if (w_rise) begin
            r_state <= ST_MEASURE;
            r_cnt   <= c_CNT_W'(1);
          end else if (w_pub) begin
            r_state <= ST_GAP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_MEASURE: begin
          if (w_pub) begin
            r_state <= ST_GAP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          // enable is only consulted here and in IDLE, so dropping it
          // mid-measurement lets the current measurement finish.
          if (r_cnt == c_GAP_LAST) begin
            r_sel <= ~r_sel;
            r_cnt <= '0;
            if (enable) begin
              r_state <= ST_TRIG;
              trigger <= sel_onehot(~r_sel);
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          trigger <= 2'b00;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ultrasonic_scheduler                                         |
// | Purpose  : Self-checking bench for ultrasonic_scheduler. Echo scenarios    |
// |            are randomized; expected trigger timing, publish timing,        |
// |            result values and levels come from a cycle-arithmetic model.    |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ultrasonic_scheduler;

  localparam int TRIG_CYCLES  = 5;
  localparam int ECHO_TIMEOUT = 100;
  localparam int GAP_CYCLES   = 20;
  localparam int TH1          = 10;
  localparam int TH2          = 30;
  localparam int TH3          = 60;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  echo   = 2'b00;
  logic [1:0]  trigger;
  logic        result_valid;
  logic        result_id;
  logic [20:0] result_cycles;
  logic        result_timeout;
  logic [1:0]  level0;
  logic [1:0]  level1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic       exp_sel = 1'b0;
  logic [1:0] exp_lvl [2];
  int         exp_t   = 0;

  ultrasonic_scheduler #(
    .TRIG_CYCLES  (TRIG_CYCLES),
    .ECHO_TIMEOUT (ECHO_TIMEOUT),
    .GAP_CYCLES   (GAP_CYCLES),
    .TH1          (TH1),
    .TH2          (TH2),
    .TH3          (TH3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .echo           (echo),
    .trigger        (trigger),
    .result_valid   (result_valid),
    .result_id      (result_id),
    .result_cycles  (result_cycles),
    .result_timeout (result_timeout),
    .level0         (level0),
    .level1         (level1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to just after the next rising edge: outputs are stable, inputs
  // driven here are seen by the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] ref_level(input int cycles, input bit to);
    if (to)                return 2'd3;
    else if (cycles < TH1) return 2'd0;
    else if (cycles < TH2) return 2'd1;
    else if (cycles < TH3) return 2'd2;
    else                   return 2'd3;
  endfunction

  // Wait (bounded) for a trigger pulse to start; returns its first cycle or -1.
  task automatic wait_trig(output int t);
    int stray;
    stray = 0;
    t     = -1;
    echo  = 2'b00;
    for (int i = 0; i < 400; i++) begin
      step();
      if (trigger != 2'b00) begin
        t = cyc;
        break;
      end
      if (result_valid) stray++;
    end
    chk_eq("trig_seen", longint'(t >= 0), 1);
    chk_eq("trig_start", t, exp_t);
    chk_eq("trig_sel", trigger, exp_sel ? 2 : 1);
    chk_eq("stray_valid", stray, 0);
  endtask

  // One full measurement. The raw echo of the selected sensor is high for
  // cycles w+d .. w+d+h-1, where w is the first cycle after the trigger.
  task automatic run_meas(input int d, input int h, input bit drop);
    int         t, w, p, k, ecyc, ntrig, trig_bad, nvalid, vcyc, hold;
    bit         eto;
    logic       s;
    logic [1:0] oh, e, lvl_s, lvl_o;
    logic       got_id, got_to;
    int         got_cyc;

    wait_trig(t);
    if (t < 0) return;
    s  = exp_sel;
    oh = s ? 2'b10 : 2'b01;
    w  = t + TRIG_CYCLES;

    // Reference: the synchronized line rises 2 cycles after the raw line.
    // A rise inside the waiting window starts timing; the measured time is
    // the high duration capped at the timeout; the result appears one cycle
    // after the deciding cycle. Otherwise the window expires.
    if (h > 0 && d >= 0 && d + 2 <= ECHO_TIMEOUT - 1) begin
      k = w + d + 2;
      if (h > ECHO_TIMEOUT) begin
        ecyc = ECHO_TIMEOUT;
        eto  = 1'b1;
      end else begin
        ecyc = h;
        eto  = 1'b0;
      end
      p = k + ecyc + 1;
    end else begin
      ecyc = 0;
      eto  = 1'b1;
      p    = w + ECHO_TIMEOUT;
    end

    ntrig    = 1;
    trig_bad = 0;
    nvalid   = 0;
    vcyc     = -1;
    hold     = -1;
    got_id   = 1'b0;
    got_to   = 1'b0;
    got_cyc  = -1;
    lvl_s    = 2'd0;
    lvl_o    = 2'd0;
    while (cyc < p + GAP_CYCLES - 1) begin
      e = 2'b00;
      if ((cyc - w) >= d && (cyc - w) < d + h) e[s] = 1'b1;
      if (cyc < p) e[~s] = 1'($urandom);
      echo = e;
      if (drop && cyc == w + 8) enable = 1'b0;
      step();
      if (trigger == oh) ntrig++;
      else if (trigger != 2'b00) trig_bad++;
      if (result_valid) begin
        nvalid++;
        if (vcyc < 0) begin
          vcyc    = cyc;
          got_id  = result_id;
          got_cyc = int'(result_cycles);
          got_to  = result_timeout;
          lvl_s   = s ? level1 : level0;
          lvl_o   = s ? level0 : level1;
        end
      end
      if (cyc == p + 10) hold = int'(result_cycles);
    end

    chk_eq("trig_width", ntrig, TRIG_CYCLES);
    chk_eq("trig_other", trig_bad, 0);
    chk_eq("valid_count", nvalid, 1);
    chk_eq("valid_cycle", vcyc, p);
    chk_eq("res_id", got_id, s);
    chk_eq("res_cycles", got_cyc, ecyc);
    chk_eq("res_timeout", got_to, eto);
    chk_eq("level_sel", lvl_s, ref_level(ecyc, eto));
    chk_eq("level_other", lvl_o, exp_lvl[~s]);
    chk_eq("res_hold", hold, ecyc);

    exp_lvl[s] = ref_level(ecyc, eto);
    exp_sel    = ~s;
    echo       = 2'b00;
    if (!drop) begin
      exp_t = p + GAP_CYCLES;
    end else begin
      int idle_bad;
      idle_bad = 0;
      for (int i = 0; i < 8; i++) begin
        step();
        if (trigger != 2'b00 || result_valid) idle_bad++;
      end
      chk_eq("idle_after_drop", idle_bad, 0);
      enable = 1'b1;
      exp_t  = cyc + 1;
    end
  endtask

  task automatic run_random();
    int kind, d, h;
    int bnd [10] = '{1, 9, 10, 29, 30, 59, 60, 99, 100, 101};
    kind = int'($urandom_range(0, 9));
    case (kind)
      0: begin d = -1000; h = 0; end
      1: begin d = int'($urandom_range(98, 110)); h = 5; end
      2: begin d = -4; h = 120; end
      3: begin d = int'($urandom_range(0, 20)); h = int'($urandom_range(101, 115)); end
      4, 5: begin d = int'($urandom_range(0, 30)); h = bnd[$urandom_range(0, 9)]; end
      default: begin d = int'($urandom_range(0, 40)); h = int'($urandom_range(1, 99)); end
    endcase
    run_meas(d, h, ($urandom_range(0, 7) == 0));
  endtask

  task automatic reset_mid_trig();
    int t;
    wait_trig(t);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk_eq("rst_trig", trigger, 0);
    chk_eq("rst_valid", result_valid, 0);
    chk_eq("rst_id", result_id, 0);
    chk_eq("rst_cycles", result_cycles, 0);
    chk_eq("rst_timeout", result_timeout, 0);
    chk_eq("rst_level0", level0, 0);
    chk_eq("rst_level1", level1, 0);
    step();
    step();
    rst_n      = 1'b1;
    exp_t      = cyc + 1;
    exp_sel    = 1'b0;
    exp_lvl[0] = 2'd0;
    exp_lvl[1] = 2'd0;
  endtask

  initial begin
    int idle_bad;
    exp_lvl[0] = 2'd0;
    exp_lvl[1] = 2'd0;

    repeat (3) step();
    chk_eq("init_trig", trigger, 0);
    chk_eq("init_valid", result_valid, 0);
    chk_eq("init_cycles", result_cycles, 0);
    chk_eq("init_timeout", result_timeout, 0);
    chk_eq("init_level0", level0, 0);
    chk_eq("init_level1", level1, 0);

    rst_n    = 1'b1;
    idle_bad = 0;
    repeat (5) begin
      step();
      if (trigger != 2'b00) idle_bad++;
    end
    chk_eq("idle_disabled", idle_bad, 0);

    enable = 1'b1;
    exp_t  = cyc + 1;
    run_meas(3, 40, 1'b0);      // sensor 0: 40-cycle echo, class 2
    run_meas(5, 115, 1'b0);     // sensor 1: echo outlasts timeout
    run_meas(-1000, 0, 1'b0);   // sensor 0: no echo at all
    run_meas(3, 8, 1'b1);       // sensor 1: enable dropped mid-measure

    for (int i = 0; i < 24; i++) run_random();
    reset_mid_trig();
    for (int i = 0; i < 4; i++) run_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
